// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-master SDRAM arbiter: FSM state encoding and master IDs.
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;

   typedef logic mst_id_t;

   localparam mst_id_t MST0 = 1'b0;
   localparam mst_id_t MST1 = 1'b1;

   function automatic arb_state_t gnt_state(input mst_id_t id);
      return (id == MST1) ? GNT1 : GNT0;
   endfunction

endpackage

// File: rtl/sdram_arb_pend_fifo.sv
// In-order FIFO of master IDs for reads accepted by the SDRAM controller but not yet returned.
module sdram_arb_pend_fifo
   import sdram_arb_pkg::*;
#(
   parameter int MAX_PEND = 4
)(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    push,
   input  logic    pop,
   input  mst_id_t din,
   output mst_id_t dout,
   output logic    full,
   output logic    empty
);

   localparam int PTR_W = $clog2(MAX_PEND);
   localparam int CNT_W = PTR_W + 1;

   mst_id_t          r_mem [MAX_PEND];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign full   = (r_count == CNT_W'(MAX_PEND));
   assign empty  = (r_count == '0);
   assign dout   = r_mem[r_rd_ptr];
   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;

   // MAX_PEND is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < MAX_PEND; i++) begin
            r_mem[i] <= MST0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= din;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-master Avalon-MM arbiter in front of the SDRAM controller, with read-return routing.
// Define SDRAM_ARB_FIXED_PRIO_EN for fixed m0-first priority instead of round robin.
//
// state | meaning
// IDLE  | no grant; s_* idle, both masters stalled
// GNT0  | master 0 owns the slave port
// GNT1  | master 1 owns the slave port
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int ADDR_W   = 25,
   parameter int DATA_W   = 32,
   parameter int MAX_PEND = 4
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic [ADDR_W-1:0]   s_address,
   output logic                s_read,
   output logic                s_write,
   output logic [DATA_W-1:0]   s_writedata,
   output logic [DATA_W/8-1:0] s_byteenable,
   input  logic                s_waitrequest,
   input  logic [DATA_W-1:0]   s_readdata,
   input  logic                s_readdatavalid,
   output logic                err
);

   arb_state_t          r_state;
   arb_state_t          w_state_nxt;
   mst_id_t             r_rr_last;
   logic                r_held;
   logic                r_err;

   logic                w_req0;
   logic                w_req1;
   logic                w_gnt;
   logic                w_sel1;
   mst_id_t             w_g_id;
   logic                w_g_read;
   logic                w_g_write;
   logic                w_g_req;
   logic                w_g_rd_only;
   logic [ADDR_W-1:0]   w_g_address;
   logic [DATA_W-1:0]   w_g_writedata;
   logic [DATA_W/8-1:0] w_g_byteenable;
   logic                w_full;
   logic                w_empty;
   mst_id_t             w_head;
   logic                w_blocked;
   logic                w_accept;
   logic                w_push;
   logic                w_pop;
   mst_id_t             w_pick;
   logic                w_held_nxt;
   logic                w_err_proto;
   logic                w_err_set;

   assign w_req0         = m0_read | m0_write;
   assign w_req1         = m1_read | m1_write;
   assign w_gnt          = (r_state != IDLE);
   assign w_sel1         = (r_state == GNT1);
   assign w_g_id         = w_sel1 ? MST1 : MST0;
   assign w_g_read       = w_sel1 ? m1_read       : m0_read;
   assign w_g_write      = w_sel1 ? m1_write      : m0_write;
   assign w_g_address    = w_sel1 ? m1_address    : m0_address;
   assign w_g_writedata  = w_sel1 ? m1_writedata  : m0_writedata;
   assign w_g_byteenable = w_sel1 ? m1_byteenable : m0_byteenable;
   assign w_g_req        = w_g_read | w_g_write;
   // read+write together is forwarded as a write, so only a pure read needs a FIFO slot
   assign w_g_rd_only    = w_g_read & ~w_g_write;

   assign w_blocked = w_gnt & w_g_rd_only & w_full;
   assign w_accept  = w_gnt & w_g_req & ~s_waitrequest & ~w_blocked;
   assign w_push    = w_accept & w_g_rd_only;
   assign w_pop     = s_readdatavalid & ~w_empty;

   sdram_arb_pend_fifo #(
      .MAX_PEND (MAX_PEND)
   ) u_pend_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_g_id),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty)
   );

   always_comb begin
      w_pick = MST0;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      w_pick = w_req0 ? MST0 : MST1;
`else
      // On acceptance the accepted master becomes the one to skip next.
      if (w_req0 && w_req1) begin
         w_pick = ((w_accept ? w_g_id : r_rr_last) == MST1) ? MST0 : MST1;
      end else begin
         w_pick = w_req0 ? MST0 : MST1;
      end
`endif
   end

   // r_held marks a request seen but not yet accepted; only then is a dropped request a violation.
   always_comb begin
      w_state_nxt = r_state;
      w_err_proto = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_req0 || w_req1) begin
               w_state_nxt = gnt_state(w_pick);
            end
         end
         GNT0, GNT1: begin
            if (w_accept) begin
               w_state_nxt = gnt_state(w_pick);
            end else if (!w_g_req && r_held) begin
               w_err_proto = 1'b1;
               w_state_nxt = IDLE;
            end else if (!w_g_req) begin
               w_state_nxt = (w_req0 || w_req1) ? gnt_state(w_pick) : IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_held_nxt = (w_state_nxt == GNT0) ? (w_req0 & ~(w_accept & ~w_sel1)) :
                       (w_state_nxt == GNT1) ? (w_req1 & ~(w_accept &  w_sel1)) : 1'b0;

   assign w_err_set = w_err_proto
                    | (s_readdatavalid & w_empty)
                    | (m0_read & m0_write)
                    | (m1_read & m1_write);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_rr_last <= MST1;
         r_held    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_held  <= w_held_nxt;
         if (w_accept) begin
            r_rr_last <= w_g_id;
         end
         if (w_err_set) begin
            r_err <= 1'b1;
         end
      end
   end

   assign s_address    = w_gnt ? w_g_address    : '0;
   assign s_writedata  = w_gnt ? w_g_writedata  : '0;
   assign s_byteenable = w_gnt ? w_g_byteenable : '0;
   assign s_write      = w_gnt & w_g_write;
   assign s_read       = w_gnt & w_g_rd_only & ~w_full;

   assign m0_waitrequest = (r_state == GNT0) ? (s_waitrequest | w_blocked) : 1'b1;
   assign m1_waitrequest = (r_state == GNT1) ? (s_waitrequest | w_blocked) : 1'b1;

   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;
   assign m0_readdatavalid = w_pop & (w_head == MST0);
   assign m1_readdatavalid = w_pop & (w_head == MST1);

   assign err = r_err;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed steps plus a randomized two-master phase
// against a transaction-level model. Honours SDRAM_ARB_FIXED_PRIO_EN for the ordering check.
module tb_sdram_arbiter;

   localparam int ADDR_W   = 25;
   localparam int DATA_W   = 32;
   localparam int BE_W     = DATA_W / 8;
   localparam int MAX_PEND = 4;

   logic              clk;
   logic              rst_n;
   logic [ADDR_W-1:0] m0_address,   m1_address;
   logic              m0_read,      m1_read;
   logic              m0_write,     m1_write;
   logic [DATA_W-1:0] m0_writedata, m1_writedata;
   logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
   logic              m0_waitrequest, m1_waitrequest;
   logic [DATA_W-1:0] m0_readdata,  m1_readdata;
   logic              m0_readdatavalid, m1_readdatavalid;
   logic [ADDR_W-1:0] s_address;
   logic              s_read, s_write;
   logic [DATA_W-1:0] s_writedata;
   logic [BE_W-1:0]   s_byteenable;
   logic              s_waitrequest;
   logic [DATA_W-1:0] s_readdata;
   logic              s_readdatavalid;
   logic              err;

   sdram_arbiter #(
      .ADDR_W (ADDR_W), .DATA_W (DATA_W), .MAX_PEND (MAX_PEND)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .m0_address (m0_address), .m0_read (m0_read), .m0_write (m0_write),
      .m0_writedata (m0_writedata), .m0_byteenable (m0_byteenable),
      .m0_waitrequest (m0_waitrequest), .m0_readdata (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address (m1_address), .m1_read (m1_read), .m1_write (m1_write),
      .m1_writedata (m1_writedata), .m1_byteenable (m1_byteenable),
      .m1_waitrequest (m1_waitrequest), .m1_readdata (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .s_address (s_address), .s_read (s_read), .s_write (s_write),
      .s_writedata (s_writedata), .s_byteenable (s_byteenable),
      .s_waitrequest (s_waitrequest), .s_readdata (s_readdata),
      .s_readdatavalid (s_readdatavalid), .err (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_chk  = 0;
   int n_fail = 0;

   // master-side transaction model
   bit                mv   [2];
   bit                mrd  [2];
   logic [ADDR_W-1:0] ma   [2];
   logic [DATA_W-1:0] md   [2];
   logic [BE_W-1:0]   mbe  [2];
   int                mage [2];
   int                idq  [$];
   int                rq   [$];
   int                cyc      = 0;
   int                last_due = 0;
   int                exp_next = -1;
   int                nbeat    = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_masters();
      m0_read       = mv[0] & mrd[0];
      m0_write      = mv[0] & ~mrd[0];
      m0_address    = ma[0];
      m0_writedata  = md[0];
      m0_byteenable = mbe[0];
      m1_read       = mv[1] & mrd[1];
      m1_write      = mv[1] & ~mrd[1];
      m1_address    = ma[1];
      m1_writedata  = md[1];
      m1_byteenable = mbe[1];
   endtask

   task automatic run_cycle(input bit gen);
      int         acc;
      int         due;
      int         eid;
      logic [1:0] wt;
      logic [1:0] rdv;
      @(negedge clk);
      wt  = {m1_waitrequest, m0_waitrequest};
      rdv = {m1_readdatavalid, m0_readdatavalid};
      acc = -1;
      for (int m = 0; m < 2; m++) begin
         if (mv[m] && !wt[m]) acc = m;
      end
      if (acc >= 0) begin
         chk("acc_swait", s_waitrequest, 1'b0);
         chk("acc_other_wait", wt[1-acc], 1'b1);
         chk("acc_addr", s_address, ma[acc]);
         chk("acc_kind", {s_read, s_write}, mrd[acc] ? 2'b10 : 2'b01);
         if (!mrd[acc]) begin
            chk("acc_wdata", s_writedata, md[acc]);
            chk("acc_be", s_byteenable, mbe[acc]);
         end
         chk("pend_bound", (mrd[acc] && idq.size() >= MAX_PEND), 1'b0);
         if (exp_next >= 0) chk("arb_order", acc, exp_next);
         exp_next = -1;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
         if (acc == 1 && mv[0]) exp_next = 0;
`else
         if (mv[1-acc]) exp_next = 1 - acc;
`endif
         if (mrd[acc]) begin
            idq.push_back(acc);
            due = cyc + int'($urandom_range(1, 4));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            rq.push_back(due);
         end
      end
      if (s_readdatavalid) begin
         eid = idq.pop_front();
         chk("rdv_route", rdv, (eid == 1) ? 2'b10 : 2'b01);
         chk("rdv_data", (eid == 1) ? m1_readdata : m0_readdata, s_readdata);
      end else begin
         chk("rdv_idle", rdv, 2'b00);
      end
      for (int m = 0; m < 2; m++) begin
         if (mv[m] && acc != m) mage[m]++;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
         if (mage[m] > 64) begin
            chk("liveness", mage[m], 64);
            mage[m] = 0;
         end
`endif
      end
      tick();
      cyc++;
      if (acc >= 0) begin
         mv[acc]   = 1'b0;
         mage[acc] = 0;
      end
      if (gen) begin
         for (int m = 0; m < 2; m++) begin
            if (!mv[m] && $urandom_range(0, 99) < 60) begin
               mv[m]  = 1'b1;
               mrd[m] = $urandom_range(0, 1) == 1;
               ma[m]  = ADDR_W'($urandom) & ~ADDR_W'(3);
               md[m]  = $urandom;
               mbe[m] = BE_W'($urandom_range(1, 15));
            end
         end
      end
      s_waitrequest = gen ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (rq.size() > 0 && rq[0] <= cyc) begin
         void'(rq.pop_front());
         s_readdatavalid = 1'b1;
         s_readdata      = 32'hA0 + DATA_W'(nbeat);
         nbeat++;
      end else begin
         s_readdatavalid = 1'b0;
      end
      drive_masters();
   endtask

   initial begin
      for (int m = 0; m < 2; m++) begin
         mv[m] = 0; mrd[m] = 0; ma[m] = '0; md[m] = '0; mbe[m] = '0; mage[m] = 0;
      end
      drive_masters();
      s_waitrequest   = 1'b0;
      s_readdata      = '0;
      s_readdatavalid = 1'b0;
      rst_n           = 1'b0;
      repeat (2) @(posedge clk);

      // reset state
      @(negedge clk);
      chk("rst_m0_wait", m0_waitrequest, 1'b1);
      chk("rst_m1_wait", m1_waitrequest, 1'b1);
      chk("rst_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
      chk("rst_s_rw", {s_read, s_write}, 2'b00);
      chk("rst_s_addr", s_address, '0);
      chk("rst_s_data", {s_writedata, s_byteenable}, '0);
      chk("rst_err", err, 1'b0);
      tick();
      rst_n = 1'b1;

      // single m0 write: visible on the slave in its 2nd request cycle
      m0_address = 25'h100; m0_write = 1'b1; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
      @(negedge clk);
      chk("wr_c1_swrite", s_write, 1'b0);
      chk("wr_c1_m0wait", m0_waitrequest, 1'b1);
      chk("wr_c1_m1wait", m1_waitrequest, 1'b1);
      tick();
      @(negedge clk);
      chk("wr_c2_swrite", s_write, 1'b1);
      chk("wr_c2_addr", s_address, 25'h100);
      chk("wr_c2_data", s_writedata, 32'hDEADBEEF);
      chk("wr_c2_be", s_byteenable, 4'hF);
      chk("wr_c2_m0wait", m0_waitrequest, 1'b0);
      chk("wr_c2_m1wait", m1_waitrequest, 1'b1);
      tick();
      m0_write = 1'b0;
      @(negedge clk);
      chk("wr_c3_swrite", s_write, 1'b0);
      chk("wr_c3_m1wait", m1_waitrequest, 1'b1);
      tick();

      // randomized two-master traffic
      drive_masters();
      for (int i = 0; i < 1500; i++) run_cycle(1'b1);
      for (int i = 0; i < 300 && (mv[0] || mv[1] || rq.size() > 0 || s_readdatavalid); i++)
         run_cycle(1'b0);
      chk("drain_done", idq.size(), 0);
      chk("rand_err", err, 1'b0);
      repeat (3) tick();

      // FIFO-full blocking: 4 reads accepted, 5th held until a beat returns
      m0_read = 1'b1; m0_address = 25'h200; s_waitrequest = 1'b0;
      @(negedge clk);
      tick();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("ovf_acc_wait", m0_waitrequest, 1'b0);
         chk("ovf_acc_sread", s_read, 1'b1);
         chk("ovf_acc_addr", s_address, 25'h200 + ADDR_W'(4 * i));
         tick();
         m0_address = m0_address + 25'd4;
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("ovf_blk_wait", m0_waitrequest, 1'b1);
         chk("ovf_blk_sread", s_read, 1'b0);
         tick();
      end
      s_readdatavalid = 1'b1; s_readdata = 32'h55;
      @(negedge clk);
      chk("ovf_pop_wait", m0_waitrequest, 1'b1);
      chk("ovf_pop_sread", s_read, 1'b0);
      chk("ovf_pop_rdv", m0_readdatavalid, 1'b1);
      tick();
      s_readdatavalid = 1'b0;
      @(negedge clk);
      chk("ovf_5th_wait", m0_waitrequest, 1'b0);
      chk("ovf_5th_sread", s_read, 1'b1);
      chk("ovf_5th_addr", s_address, 25'h210);
      tick();
      m0_read = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s_readdatavalid = 1'b1; s_readdata = 32'hB0 + DATA_W'(i);
         @(negedge clk);
         chk("ovf_drain_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b01);
         chk("ovf_drain_data", m0_readdata, 32'hB0 + DATA_W'(i));
         tick();
      end
      s_readdatavalid = 1'b0;
      @(negedge clk);
      chk("ovf_err", err, 1'b0);
      tick();

      // beat with nothing pending: dropped and flagged, err sticky
      s_readdatavalid = 1'b1; s_readdata = 32'h77;
      @(negedge clk);
      chk("empty_pop_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
      tick();
      s_readdatavalid = 1'b0;
      @(negedge clk);
      chk("empty_pop_err", err, 1'b1);
      repeat (5) tick();
      @(negedge clk);
      chk("err_sticky", err, 1'b1);
      tick();

      // reset while m1 holds the grant with 2 reads pending
      m1_read = 1'b1; m1_address = 25'h300;
      tick();
      for (int i = 0; i < 2; i++) begin
         tick();
         m1_address = m1_address + 25'd4;
      end
      s_waitrequest = 1'b1;
      @(negedge clk);
      chk("pre_rst_sread", s_read, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_wait", {m1_waitrequest, m0_waitrequest}, 2'b11);
      chk("mid_rst_sread", s_read, 1'b0);
      chk("mid_rst_err", err, 1'b0);
      tick();
      m1_read = 1'b0; s_waitrequest = 1'b0;
      tick();
      rst_n = 1'b1;
      s_readdatavalid = 1'b1; s_readdata = 32'h99;
      @(negedge clk);
      chk("late_beat_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
      tick();
      s_readdatavalid = 1'b0;
      @(negedge clk);
      chk("late_beat_err", err, 1'b1);
      tick();
      m0_read = 1'b1; m1_read = 1'b1; m0_address = 25'h400; m1_address = 25'h500;
      tick();
      @(negedge clk);
      chk("post_rst_m0_first", {m1_waitrequest, m0_waitrequest}, 2'b10);
      chk("post_rst_addr", s_address, 25'h400);
      tick();
      m0_read = 1'b0;
      @(negedge clk);
      chk("post_rst_m1_next", {m1_waitrequest, m0_waitrequest}, 2'b01);
      tick();
      m1_read = 1'b0;
      repeat (2) tick();

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Two-master Avalon-MM arbiter that shares the single SDRAM controller slave port in the DNN accelerator system.
- Master 0 is the DNN accelerator memory master (weights and activations). Master 1 is the word-copy/VGA framebuffer master.
- Performs round-robin grant with registered arbitration.
- Tracks outstanding pipelined reads and routes each readdatavalid beat back to the master that issued the read.

Parameters:
- ADDR_W, 25, byte-address width on all ports.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- MAX_PEND, 4, maximum outstanding reads, power of 2, ≥2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- m0_address  in  ADDR_W  master 0 address.
- m0_read / m0_write  in  1  master 0 read and write requests.
- m0_writedata  in  DATA_W  master 0 write data.
- m0_byteenable  in  DATA_W/8  master 0 byte enables.
- m0_waitrequest  out  1  stall to master 0.
- m0_readdata  out  DATA_W  read data to master 0.
- m0_readdatavalid  out  1  read beat for master 0.
- m1_*  same set as m0_*  master 1.
- s_address  out  ADDR_W  to SDRAM controller.
- s_read / s_write  out  1  to SDRAM controller.
- s_writedata  out  DATA_W  to SDRAM controller.
- s_byteenable  out  DATA_W/8  to SDRAM controller.
- s_waitrequest  in  1  from SDRAM controller.
- s_readdata  in  DATA_W  from SDRAM controller.
- s_readdatavalid  in  1  from SDRAM controller.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE, pending FIFO empty, rr_last = 1 (m0 preferred first).
  - m0_waitrequest = m1_waitrequest = 1; both readdatavalid = 0.
  - s_read = s_write = 0; s_address, s_writedata, s_byteenable = 0; err = 0.
- A master requests when read|write is high.
- FSM states: IDLE, GNT0, GNT1.
- IDLE:
  - If any request is present, select the master that is not rr_last; if only one requests, select it.
  - Next state is GNTx. Arbitration latency is 1 cycle, so a master's earliest acceptance is its 2nd cycle of request.
- GNTx:
  - s_* are driven combinationally from mx_*.
  - mx_waitrequest = s_waitrequest. The other master's waitrequest = 1.
- Acceptance = mx request & !s_waitrequest. On acceptance:
  - rr_last <= x.
  - If read, push ID x into the pending FIFO.
  - Next state: GNT(other) if the other master is requesting; else GNTx if mx is still requesting (back-to-back); else IDLE.
- Without acceptance, stay in GNTx. A grant is never revoked while a request is stalled, as the Avalon stability rule requires.
- Master deasserts without acceptance (protocol violation): set err, return to IDLE.
- Pending FIFO full (count == MAX_PEND):
  - Reads from the granted master are blocked: s_read forced 0, mx_waitrequest forced 1.
  - Blocking applies even if a pop occurs in the same cycle.
  - Writes are unaffected.
- s_readdatavalid:
  - Pop the FIFO head and assert m[head]_readdatavalid in the same cycle (combinational).
  - s_readdata is broadcast to both readdata ports.
  - If the FIFO is empty, drop the beat, assert no readdatavalid, and set err.
- Push and pop in the same cycle: count unchanged, order preserved. Pointers wrap modulo MAX_PEND.
- read & write both high on a master: set err; the transfer is forwarded as a write.
- err clears only on reset.
- Reset mid-operation clears all pending IDs. Late beats from the controller are then flagged via err.

Optional Feature:
- Macro: SDRAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. In IDLE and at each acceptance, m0 wins whenever it requests, and rr_last is ignored.
- Undefined: round robin as above.
- Pending tracking and err behaviour are identical in both modes.

Decomposition:
- Package sdram_arb_pkg holds:
  - state enum arb_state_t {IDLE, GNT0, GNT1};
  - typedef mst_id_t (1 bit);
  - constants MST0 and MST1.
- Sub-module sdram_arb_pend_fifo:
  - MAX_PEND-deep FIFO of mst_id_t;
  - ports push, pop, din, dout, full, empty;
  - count register of width $clog2(MAX_PEND)+1.

Test Plan:
- Reset, then m0 writes 0xDEADBEEF to 0x100 with s_waitrequest=0 → s_write=1 on cycle 2 with m0's address/data; m0_waitrequest=0 that cycle; m1_waitrequest=1 throughout.
- m0 and m1 issue continuous reads, s_waitrequest=0, readdatavalid returned 3 cycles later → grants alternate m0,m1,m0,m1; each beat 0xA0+n reaches the issuing master in order; FIFO never exceeds 4.
- m0 issues 5 reads, no readdatavalid → 4 accepted; 5th held with m0_waitrequest=1 and s_read=0 until the first beat returns; accepted the following cycle.
- s_readdatavalid pulsed with FIFO empty → no master readdatavalid; err=1 and stays 1 until rst_n low.
- rst_n asserted low while in GNT1 with 2 reads pending → immediately waitrequests=1, s_read=0, FIFO empty; after release, m0 is served first.
- With SDRAM_ARB_FIXED_PRIO_EN, both masters requesting continuously → m0 granted every transfer, m1 starved.
